// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the tinymips datapath: decodes op/funct and sequences
// the datapath one state per cycle, with a req/ready handshake on memory accesses.
module mips_multicycle_ctrl #(
   parameter int unsigned ILLEGAL_HALT = 1,
   parameter int unsigned MEM_TIMEOUT  = 15
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       irwrite,
   output logic       memwrite,
   output logic       mem2reg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alu_control,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [3:0] state,
   output logic       illegal,
   output logic       err_timeout
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_LAST =
      (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);
   localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam bit HALT_ON_ILLEGAL = (ILLEGAL_HALT != 0);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXEC    = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      HALT    = 4'd15
   } state_t;

   state_t           state_q;
   state_t           state_d;
   state_t           illegal_next;
   logic [CNT_W-1:0] count_q;
   logic             waiting;
   logic             timeout_hit;

   assign state        = state_q;
   assign illegal_next = HALT_ON_ILLEGAL ? HALT : FETCH;

   // State register, handshake wait counter and sticky timeout flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= FETCH;
         count_q     <= '0;
         err_timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_d != state_q) || !waiting) begin
            count_q <= '0;
         end else begin
            count_q <= count_q + CNT_W'(1);
         end
         if (timeout_hit) begin
            err_timeout <= 1'b1;
         end
      end
   end

   // Next-state and Moore outputs; memory strobes follow mem_ready in the same cycle.
   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      iord        = 1'b0;
      irwrite     = 1'b0;
      memwrite    = 1'b0;
      mem2reg     = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      alu_control = ALU_ADD;
      pcsrc       = 2'b00;
      pcen        = 1'b0;
      illegal     = 1'b0;
      waiting     = 1'b0;
      timeout_hit = 1'b0;

      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcen    = mem_ready;
            if (mem_ready) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            // ALU precomputes the branch target while the opcode is decoded.
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = illegal_next;
               end
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               state_d = MEMWB;
            end
         end
         MEMWB: begin
            mem2reg  = 1'b1;
            regwrite = 1'b1;
            state_d  = FETCH;
         end
         MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = mem_ready;
            if (mem_ready) begin
               state_d = FETCH;
            end
         end
         EXEC: begin
            alusrca = 1'b1;
            state_d = ALUWB;
            case (funct)
               FN_ADD: alu_control = ALU_ADD;
               FN_SUB: alu_control = ALU_SUB;
               FN_AND: alu_control = ALU_AND;
               FN_OR:  alu_control = ALU_OR;
               FN_SLT: alu_control = ALU_SLT;
               default: begin
                  illegal = 1'b1;
                  state_d = illegal_next;
               end
            endcase
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            alusrca     = 1'b1;
            alu_control = ALU_SUB;
            pcsrc       = 2'b01;
            pcen        = zero;
            state_d     = FETCH;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = ADDIWB;
         end
         ADDIWB: begin
            regwrite = 1'b1;
            state_d  = FETCH;
         end
         JUMP: begin
            pcsrc   = 2'b10;
            pcen    = 1'b1;
            state_d = FETCH;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      waiting = mem_req && !mem_ready;
      if (TIMEOUT_EN && waiting && (count_q == TO_LAST)) begin
         timeout_hit = 1'b1;
         state_d     = HALT;
      end

      // Reset suppresses every enable so an aborted operation never writes.
      if (RST) begin
         mem_req  = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         pcen     = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class, the illegal
// paths, the write handshake stall and the handshake timeout.
module tb_mips_multicycle_ctrl;

   logic       CLK;
   logic       RST;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       iord;
   logic       irwrite;
   logic       memwrite;
   logic       mem2reg;
   logic       regdst;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [2:0] alu_control;
   logic [1:0] pcsrc;
   logic       pcen;
   logic [3:0] state;
   logic       illegal;
   logic       err_timeout;

   int checks = 0;
   int errors = 0;

   mips_multicycle_ctrl dut (
      .CLK         (CLK),
      .RST         (RST),
      .op          (op),
      .funct       (funct),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .iord        (iord),
      .irwrite     (irwrite),
      .memwrite    (memwrite),
      .mem2reg     (mem2reg),
      .regdst      (regdst),
      .regwrite    (regwrite),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .alu_control (alu_control),
      .pcsrc       (pcsrc),
      .pcen        (pcen),
      .state       (state),
      .illegal     (illegal),
      .err_timeout (err_timeout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs are then changed and outputs sampled mid-cycle.
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   logic [3:0] lw_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
   logic       lw_rw [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   int         mw_pulses;

   initial begin
      RST = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

      // reset held two cycles: enables stay low
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_state",    32'(state),    32'd0);
         check("rst_mem_req",  32'(mem_req),  32'd0);
         check("rst_irwrite",  32'(irwrite),  32'd0);
         check("rst_regwrite", 32'(regwrite), 32'd0);
         check("rst_memwrite", 32'(memwrite), 32'd0);
         check("rst_pcen",     32'(pcen),     32'd0);
         check("rst_err",      32'(err_timeout), 32'd0);
      end
      RST = 1'b0;
      #1;
      check("fetch_mem_req", 32'(mem_req), 32'd1);
      check("fetch_irwrite", 32'(irwrite), 32'd1);
      check("fetch_pcen",    32'(pcen),    32'd1);
      check("fetch_alusrcb", 32'(alusrcb), 32'd1);

      // lw: 5 cycles, write-back only in the last
      op = 6'b100011;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("lw_state",    32'(state),    32'(lw_st[i]));
         check("lw_regwrite", 32'(regwrite), 32'(lw_rw[i]));
         check("lw_mem2reg",  32'(mem2reg),  32'(lw_rw[i]));
         if (i == 1) check("lw_dec_alusrcb", 32'(alusrcb), 32'd3);
         if (i == 2) check("lw_adr_alusrcb", 32'(alusrcb), 32'd2);
         if (i == 3) check("lw_rd_iord",     32'(iord),     32'd1);
         tick();
      end
      check("lw_done_state", 32'(state), 32'd0);

      // sw with three not-ready cycles in MEMWR
      op = 6'b101011;
      tick(); tick(); tick();
      mem_ready = 1'b0;
      mw_pulses = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("sw_wait_state",    32'(state),    32'd5);
         check("sw_wait_memwrite", 32'(memwrite), 32'd0);
         check("sw_wait_mem_req",  32'(mem_req),  32'd1);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("sw_memwrite", 32'(memwrite), 32'd1);
      tick();
      check("sw_done_state",    32'(state),    32'd0);
      check("sw_after_memwrite", 32'(memwrite), 32'd0);

      // R-type slt
      op = 6'b000000; funct = 6'b101010;
      tick(); tick();
      check("slt_state",   32'(state),       32'd6);
      check("slt_alu",     32'(alu_control), 32'd7);
      check("slt_alusrca", 32'(alusrca),     32'd1);
      check("slt_alusrcb", 32'(alusrcb),     32'd0);
      tick();
      check("aluwb_state",    32'(state),    32'd7);
      check("aluwb_regwrite", 32'(regwrite), 32'd1);
      check("aluwb_regdst",   32'(regdst),   32'd1);
      tick();

      // beq taken and not taken
      op = 6'b000100;
      tick(); tick();
      zero = 1'b1;
      #1;
      check("beq_state", 32'(state),       32'd8);
      check("beq_pcen1", 32'(pcen),        32'd1);
      check("beq_pcsrc", 32'(pcsrc),       32'd1);
      check("beq_alu",   32'(alu_control), 32'd6);
      zero = 1'b0;
      #1;
      check("beq_pcen0", 32'(pcen), 32'd0);
      tick();
      check("beq_done_state", 32'(state), 32'd0);

      // jump
      op = 6'b000010;
      tick(); tick();
      check("j_state", 32'(state), 32'd11);
      check("j_pcsrc", 32'(pcsrc), 32'd2);
      check("j_pcen",  32'(pcen),  32'd1);
      tick();

      // addi
      op = 6'b001000;
      tick(); tick();
      check("addi_ex_state", 32'(state),   32'd9);
      check("addi_alusrcb",  32'(alusrcb), 32'd2);
      tick();
      check("addi_wb_state", 32'(state),    32'd10);
      check("addi_regwrite", 32'(regwrite), 32'd1);
      check("addi_regdst",   32'(regdst),   32'd0);
      tick();

      // illegal funct halts until reset
      op = 6'b000000; funct = 6'b000111;
      tick(); tick();
      check("badfn_state",   32'(state),       32'd6);
      check("badfn_illegal", 32'(illegal),     32'd1);
      check("badfn_alu",     32'(alu_control), 32'd2);
      tick();
      check("badfn_halt",    32'(state),   32'd15);
      check("badfn_pulse",   32'(illegal), 32'd0);
      check("halt_mem_req",  32'(mem_req), 32'd0);
      tick(); tick();
      check("halt_sticky", 32'(state), 32'd15);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      check("rst_from_halt", 32'(state), 32'd0);

      // illegal opcode
      op = 6'b111111;
      tick();
      check("badop_state",   32'(state),   32'd1);
      check("badop_illegal", 32'(illegal), 32'd1);
      tick();
      check("badop_halt", 32'(state), 32'd15);
      RST = 1'b1;
      tick();
      RST = 1'b0;

      // fetch handshake timeout after 15 not-ready cycles
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #1;
         check("to_wait_state", 32'(state),       32'd0);
         check("to_wait_err",   32'(err_timeout), 32'd0);
         check("to_wait_irw",   32'(irwrite),     32'd0);
         tick();
      end
      check("to_state", 32'(state),       32'd15);
      check("to_err",   32'(err_timeout), 32'd1);
      mem_ready = 1'b1;
      tick();
      check("to_err_sticky", 32'(err_timeout), 32'd1);
      check("to_halt_stay",  32'(state),       32'd15);
      RST = 1'b1;
      tick();
      check("to_err_cleared", 32'(err_timeout), 32'd0);
      check("to_rst_state",   32'(state),       32'd0);
      RST = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
